irq_ctrl: RTL

Machine-mode interrupt controller for the RV32I core. It sits directly upstream of the CSR file and the trap path. It owns a 64-bit machine timer (`mtime`/`mtimecmp`), the software-interrupt bit `msip` and a synchronised external interrupt line, and publishes the resulting MSIP/MTIP/MEIP pending bits to `mip`. When an enabled interrupt is pending and `mstatus.MIE` is set, it raises a trap request carrying `trap_info` and holds it until the pipeline controller accepts it, then tracks the handler until `mret`.

---
 rtl/irq_ctrl_pkg.sv | 31 +++
 rtl/irq_ctrl_mtimer.sv | 77 +++++++
 rtl/irq_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the machine-mode trap path: CSR addresses, interrupt
// cause codes, the irq_ctrl register-map word indices, and the cause
// priority selector.
package irq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam logic [2:0] ADDR_MSIP        = 3'd0;
    localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] ADDR_MTIME_LO    = 3'd4;
    localparam logic [2:0] ADDR_MTIME_HI    = 3'd5;

    // pend_en = {MEI, MTI, MSI} already masked by the enables.
    // Priority is MEI > MSI > MTI.
    function automatic logic [3:0] sel_cause(input logic [2:0] pend_en);
        logic [3:0] cause;
        if (pend_en[2])      cause = CAUSE_MEI;
        else if (pend_en[0]) cause = CAUSE_MSI;
        else                 cause = CAUSE_MTI;
        return cause;
    endfunction

endpackage

// File: rtl/irq_ctrl_mtimer.sv
// mtimer: machine timer. Holds the prescaler, mtime and mtimecmp, their bus
// write ports, and the registered MTIP compare.
// Ports:
//   ctrl_clk, ctrl_reset_n  clock, async active-low reset
//   i_wen, i_addr, i_wdata  register write port (word index)
//   o_mtime, o_mtimecmp     current register values (for bus reads)
//   o_mtip                  registered mtime >= mtimecmp
module mtimer
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic        i_wen,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_mtip
);

    logic [15:0] r_presc;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_mtip;
    logic        w_tick;

    assign w_tick = (r_presc == 16'(TICK_DIV - 1));

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // A bus write to either half overrides the tick increment; the other
    // half keeps its value.
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_mtime <= '0;
        end else if (i_wen && i_addr == ADDR_MTIME_LO) begin
            r_mtime[31:0] <= i_wdata;
        end else if (i_wen && i_addr == ADDR_MTIME_HI) begin
            r_mtime[63:32] <= i_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_mtimecmp <= '1;
        end else if (i_wen && i_addr == ADDR_MTIMECMP_LO) begin
            r_mtimecmp[31:0] <= i_wdata;
        end else if (i_wen && i_addr == ADDR_MTIMECMP_HI) begin
            r_mtimecmp[63:32] <= i_wdata;
        end
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_mtip     = r_mtip;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller. Synchronises ext_irq, holds
// msip, instantiates the machine timer, publishes {MEIP,MTIP,MSIP} and runs
// the trap-request FSM.
// Ports:
//   ctrl_clk, ctrl_reset_n            clock, async active-low reset
//   bus_wen/ren/addr/wdata, bus_rdata register bus (rdata registered)
//   ext_irq                           async level external interrupt
//   mie_msie/mtie/meie, ctrl_mie      per-source and global enables
//   irq_pending                       {MEIP, MTIP, MSIP}
//   trap_req, trap_info, trap_ack     trap handshake, info = {1, cause}
//   ctrl_mret                         mret retired
//
// state      | meaning
// ST_IDLE    | no request; waiting for an enabled pending interrupt
// ST_REQ     | trap_req high, trap_info frozen until ack or withdrawal
// ST_HANDLER | trap taken; no new request until mret
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic        bus_wen,
    input  logic        bus_ren,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        ctrl_mie,
    output logic [2:0]  irq_pending,
    output logic        trap_req,
    output logic [4:0]  trap_info,
    input  logic        trap_ack,
    input  logic        ctrl_mret
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sync1, r_sync2;
    logic        r_msip;
    logic [31:0] r_rdata;
    logic [4:0]  r_trap_info;
    logic [31:0] w_rdata_nxt;
    logic [63:0] w_mtime, w_mtimecmp;
    logic        w_mtip;
    logic [2:0]  w_pending, w_pend_en;
    logic        w_take;

    mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
        .ctrl_clk     (ctrl_clk),
        .ctrl_reset_n (ctrl_reset_n),
        .i_wen        (bus_wen),
        .i_addr       (bus_addr),
        .i_wdata      (bus_wdata),
        .o_mtime      (w_mtime),
        .o_mtimecmp   (w_mtimecmp),
        .o_mtip       (w_mtip)
    );

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ext_irq;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_msip <= 1'b0;
        end else if (bus_wen && bus_addr == ADDR_MSIP) begin
            r_msip <= bus_wdata[0];
        end
    end

    always_comb begin
        w_rdata_nxt = '0;
        case (bus_addr)
            ADDR_MSIP:        w_rdata_nxt = {31'd0, r_msip};
            ADDR_MTIMECMP_LO: w_rdata_nxt = w_mtimecmp[31:0];
            ADDR_MTIMECMP_HI: w_rdata_nxt = w_mtimecmp[63:32];
            ADDR_MTIME_LO:    w_rdata_nxt = w_mtime[31:0];
            ADDR_MTIME_HI:    w_rdata_nxt = w_mtime[63:32];
            default:          w_rdata_nxt = '0;
        endcase
    end

    // Sampled from pre-edge register values, so a same-cycle write reads old.
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_rdata <= '0;
        end else if (bus_ren) begin
            r_rdata <= w_rdata_nxt;
        end
    end

    assign w_pending = {r_sync2, w_mtip, r_msip};
    assign w_pend_en = w_pending & {mie_meie, mie_mtie, mie_msie};
    assign w_take    = ctrl_mie && (|w_pend_en);

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // Ack wins over withdrawal when both occur together.
                if (trap_ack)      w_state_nxt = ST_HANDLER;
                else if (!ctrl_mie) w_state_nxt = ST_IDLE;
            end
            ST_HANDLER: begin
                if (ctrl_mret) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_trap_info <= '0;
        end else if (r_state == ST_IDLE && w_take) begin
            r_trap_info <= {1'b1, sel_cause(w_pend_en)};
        end
    end

    assign bus_rdata   = r_rdata;
    assign irq_pending = w_pending;
    assign trap_req    = (r_state == ST_REQ);
    assign trap_info   = r_trap_info;

endmodule
